// File: rtl/fn_rr_scheduler.sv
// Round-robin scheduler sharing one function-chooser among N 4-phase req/ack clients.
// Requests and the chooser's done are synchronised; start/sel/ack/err are registered.
module fn_rr_scheduler #(
    parameter int N       = 4,
    parameter int TIMEOUT = 255
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req,
    output logic [N-1:0] ack,
    output logic [N-1:0] sel,
    output logic         start,
    input  logic         done,
    output logic         chooser_rst,
    output logic         busy,
    output logic         err,
    output logic [7:0]   to_cnt
);

    localparam int PW = (N > 1) ? $clog2(N) : 1;
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [1:0] {IDLE, BUSY, DRAIN, ACK} state_t;

    state_t         state, state_nxt;
    logic [N-1:0]   req_m, req_s;
    logic           done_m, done_s;
    logic [PW-1:0]  ptr, gnt, pick;
    logic [TW-1:0]  timer;
    logic           aborted;
    logic           tmo;

    function automatic logic [PW-1:0] rr_pick(input logic [N-1:0] r, input logic [PW-1:0] p);
        logic [PW-1:0] res;
        logic          found;
        logic [PW-1:0] idx_b;
        int            idx;
        res   = p;
        found = 1'b0;
        for (int i = 0; i < N; i++) begin
            idx = int'(p) + i;
            if (idx >= N) idx = idx - N;
            idx_b = PW'(idx);
            if (!found && r[idx_b]) begin
                found = 1'b1;
                res   = idx_b;
            end
        end
        return res;
    endfunction

    function automatic logic [N-1:0] onehot(input logic [PW-1:0] g);
        return {{(N-1){1'b0}}, 1'b1} << g;
    endfunction

    function automatic logic [7:0] sat_inc(input logic [7:0] c);
        return (c == 8'hFF) ? c : c + 8'd1;
    endfunction

    function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] g);
        return (int'(g) == N - 1) ? '0 : g + PW'(1);
    endfunction

    assign pick = rr_pick(req_s, ptr);
    assign tmo  = (timer == TW'(TIMEOUT - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req_m  <= '0;
            req_s  <= '0;
            done_m <= 1'b0;
            done_s <= 1'b0;
        end else begin
            req_m  <= req;
            req_s  <= req_m;
            done_m <= done;
            done_s <= done_m;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (|req_s)             state_nxt = BUSY;
            BUSY:    if (done_s || tmo)      state_nxt = DRAIN;
            DRAIN:   if (!done_s || tmo)     state_nxt = ACK;
            ACK:     if (!req_s[gnt])        state_nxt = IDLE;
            default:                         state_nxt = IDLE;
        endcase
    end

    always_comb begin
        chooser_rst = (state == IDLE);
        busy        = (state != IDLE);
    end

    // Datapath: aborted remembers a BUSY timeout so err only appears together with ack.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ack     <= '0;
            sel     <= '0;
            start   <= 1'b0;
            err     <= 1'b0;
            to_cnt  <= '0;
            ptr     <= '0;
            gnt     <= '0;
            timer   <= '0;
            aborted <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (|req_s) begin
                        gnt     <= pick;
                        sel     <= onehot(pick);
                        start   <= 1'b1;
                        timer   <= '0;
                        aborted <= 1'b0;
                    end
                end
                BUSY: begin
                    if (done_s) begin
                        start <= 1'b0;
                        timer <= '0;
                    end else if (tmo) begin
                        start   <= 1'b0;
                        timer   <= '0;
                        aborted <= 1'b1;
                        to_cnt  <= sat_inc(to_cnt);
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end
                DRAIN: begin
                    if (!done_s) begin
                        ack   <= onehot(gnt);
                        sel   <= '0;
                        err   <= aborted;
                        timer <= '0;
                    end else if (tmo) begin
                        ack    <= onehot(gnt);
                        sel    <= '0;
                        err    <= 1'b1;
                        timer  <= '0;
                        to_cnt <= sat_inc(to_cnt);
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end
                ACK: begin
                    if (!req_s[gnt]) begin
                        ack <= '0;
                        err <= 1'b0;
                        ptr <= ptr_next(gnt);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fn_rr_scheduler.sv
// Self-checking bench for fn_rr_scheduler: scenario tasks plus randomized transactions
// compared against a transaction-level round-robin model.
module tb_fn_rr_scheduler;

    localparam int N   = 4;
    localparam int TMO = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic [N-1:0] req;
    logic [N-1:0] ack;
    logic [N-1:0] sel;
    logic         start;
    logic         done;
    logic         chooser_rst;
    logic         busy;
    logic         err;
    logic [7:0]   to_cnt;

    int n_total = 0;
    int n_pass  = 0;

    logic [N-1:0] model_req;
    int           model_ptr;
    int           model_to;
    bit           ack2_seen;

    fn_rr_scheduler #(.N(N), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst), .req(req), .ack(ack), .sel(sel), .start(start),
        .done(done), .chooser_rst(chooser_rst), .busy(busy), .err(err), .to_cnt(to_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time exceeded");
        $fatal(1, "watchdog");
    end

    // Continuous invariants on the handshake outputs.
    always @(negedge clk) begin
        if (rst === 1'b0) begin
            n_total++;
            if (!($onehot0(ack) && $onehot0(sel) && (!err || ack != '0)))
                $display("FAIL invariant: ack=%b sel=%b err=%b", ack, sel, err);
            else
                n_pass++;
            if (ack[2]) ack2_seen = 1'b1;
        end
    end

    function automatic int model_grant();
        for (int i = 0; i < N; i++) begin
            if (model_req[(model_ptr + i) % N]) return (model_ptr + i) % N;
        end
        return -1;
    endfunction

    // mode 0: done after d cycles; mode 1: done never rises; mode 2: done rises and sticks high.
    task automatic do_txn(input int mode, input int d, input logic [N-1:0] raise,
                          input logic [N-1:0] pulse);
        int           cyc;
        int           eg;
        logic [N-1:0] exp_sel;
        eg = model_grant();
        exp_sel = (eg < 0) ? '0 : (N'(1) << eg);
        cyc = 0;
        while (start !== 1'b1 && cyc < 60) begin @(negedge clk); cyc++; end
        n_total++;
        if (start !== 1'b1) begin
            $display("FAIL start_wait: start=%b after %0d cycles, required 1", start, cyc);
            return;
        end
        n_pass++;
        n_total++;
        if (sel !== exp_sel || chooser_rst !== 1'b0 || busy !== 1'b1)
            $display("FAIL grant: sel=%b chooser_rst=%b busy=%b, required sel=%b 0 1",
                     sel, chooser_rst, busy, exp_sel);
        else n_pass++;
        req       = req | raise;
        model_req = model_req | raise;
        if (pulse != '0) begin
            @(negedge clk); req = req | pulse;
            @(negedge clk); req = req & ~pulse;
        end
        if (mode != 1) begin
            repeat (d) @(negedge clk);
            done = 1'b1;
        end
        cyc = 0;
        while (start !== 1'b0 && cyc < 40) begin @(negedge clk); cyc++; end
        if (mode == 1) begin
            n_total++;
            if (cyc != TMO) $display("FAIL timeout_len: start low after %0d cycles, required %0d", cyc, TMO);
            else n_pass++;
        end
        if (mode == 0) begin
            repeat (2) @(negedge clk);
            done = 1'b0;
        end
        cyc = 0;
        while (ack === '0 && cyc < 40) begin @(negedge clk); cyc++; end
        if (mode != 0) model_to = (model_to < 255) ? model_to + 1 : 255;
        n_total++;
        if (ack !== exp_sel || sel !== '0 || err !== (mode != 0) || to_cnt !== 8'(model_to))
            $display("FAIL ack_phase: ack=%b sel=%b err=%b to_cnt=%0d, required ack=%b sel=0 err=%b to_cnt=%0d",
                     ack, sel, err, to_cnt, exp_sel, (mode != 0), model_to);
        else n_pass++;
        if (mode == 2) done = 1'b0;
        req       = req & ~exp_sel;
        model_req = model_req & ~exp_sel;
        if (eg >= 0) model_ptr = (eg + 1) % N;
        cyc = 0;
        while (ack !== '0 && cyc < 20) begin @(negedge clk); cyc++; end
        n_total++;
        if (ack !== '0 || err !== 1'b0 || busy !== 1'b0 || chooser_rst !== 1'b1)
            $display("FAIL release: ack=%b err=%b busy=%b chooser_rst=%b, required 0 0 0 1",
                     ack, err, busy, chooser_rst);
        else n_pass++;
    endtask

    task automatic test_reset();
        rst = 1'b1; req = '0; done = 1'b0;
        model_req = '0; model_ptr = 0; model_to = 0; ack2_seen = 1'b0;
        #3;
        n_total++;
        if (ack !== '0 || sel !== '0 || start !== 1'b0 || err !== 1'b0 || busy !== 1'b0 ||
            chooser_rst !== 1'b1 || to_cnt !== 8'd0)
            $display("FAIL reset: ack=%b sel=%b start=%b err=%b busy=%b crst=%b to_cnt=%0d, required 0 0 0 0 0 1 0",
                     ack, sel, start, err, busy, chooser_rst, to_cnt);
        else n_pass++;
        repeat (3) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_alternate();
        @(negedge clk);
        req = 4'b1010; model_req = 4'b1010;
        do_txn(0, 3, '0, '0);
        do_txn(0, 2, '0, '0);
    endtask

    task automatic test_continuous();
        int prev;
        @(negedge clk);
        req = 4'b1111; model_req = 4'b1111;
        prev = -1;
        for (int k = 0; k < 5; k++) begin
            int eg;
            eg = model_grant();
            n_total++;
            if (eg != (k % N)) $display("FAIL rr_order: model grant %0d, required %0d", eg, k % N);
            else n_pass++;
            do_txn(0, $urandom_range(1, 5), (prev < 0 || k == 4) ? '0 : (N'(1) << prev), '0);
            prev = eg;
        end
        while (model_req != '0) do_txn(0, $urandom_range(1, 5), '0, '0);
    endtask

    task automatic test_single();
        @(negedge clk);
        req = 4'b0001; model_req = 4'b0001;
        @(negedge clk);
        n_total++;
        if (start !== 1'b0) $display("FAIL latency_e1: start=%b, required 0", start); else n_pass++;
        @(negedge clk);
        n_total++;
        if (start !== 1'b0) $display("FAIL latency_e2: start=%b, required 0", start); else n_pass++;
        @(negedge clk);
        n_total++;
        if (start !== 1'b1) $display("FAIL latency_e3: start=%b, required 1", start); else n_pass++;
        do_txn(0, 5, '0, '0);
    endtask

    task automatic test_timeout();
        @(negedge clk);
        req = 4'b0100; model_req = 4'b0100;
        do_txn(1, 0, '0, '0);
    endtask

    task automatic test_drain_timeout();
        @(negedge clk);
        req = 4'b1000; model_req = 4'b1000;
        do_txn(2, 2, '0, '0);
    endtask

    task automatic test_pulse();
        @(negedge clk);
        ack2_seen = 1'b0;
        req = 4'b0001; model_req = 4'b0001;
        do_txn(0, 2, '0, 4'b0100);
        repeat (15) @(negedge clk);
        n_total++;
        if (ack2_seen || busy !== 1'b0)
            $display("FAIL pulse_ignored: ack2_seen=%b busy=%b, required 0 0", ack2_seen, busy);
        else n_pass++;
    endtask

    task automatic test_random();
        for (int k = 0; k < 30; k++) begin
            int r;
            logic [N-1:0] rm;
            if (model_req == '0) begin
                @(negedge clk);
                rm = N'($urandom_range(1, 15));
                req = rm; model_req = rm;
            end
            rm = ($urandom_range(0, 1) == 1) ? N'($urandom_range(0, 15)) : '0;
            r = $urandom_range(0, 9);
            if (r < 7)      do_txn(0, $urandom_range(1, 5), rm, '0);
            else if (r < 9) do_txn(1, 0, rm, '0);
            else            do_txn(2, $urandom_range(1, 3), rm, '0);
        end
    endtask

    task automatic test_rst_mid_busy();
        int cyc;
        req = req | 4'b0100;
        cyc = 0;
        while (start !== 1'b1 && cyc < 60) begin @(negedge clk); cyc++; end
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        n_total++;
        if (start !== 1'b0 || sel !== '0 || ack !== '0 || busy !== 1'b0 ||
            chooser_rst !== 1'b1 || to_cnt !== 8'd0)
            $display("FAIL rst_mid: start=%b sel=%b ack=%b busy=%b crst=%b to_cnt=%0d, required 0 0 0 0 1 0",
                     start, sel, ack, busy, chooser_rst, to_cnt);
        else n_pass++;
        @(negedge clk);
        done = 1'b0; req = 4'b1111;
        model_req = 4'b1111; model_ptr = 0; model_to = 0;
        @(negedge clk);
        rst = 1'b0;
        do_txn(0, 3, '0, '0);
    endtask

    initial begin
        test_reset();
        test_alternate();
        test_continuous();
        test_single();
        test_timeout();
        test_drain_timeout();
        test_pulse();
        test_random();
        test_rst_mid_busy();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
